branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Dynamic branch predictor and branch target buffer (BTB) for the 5-stage pipeline.
- Sits upstream of the hazard unit:
  - Fetch gets a predicted next PC every cycle.
  - Resolved branches from the EX/MEM boundary train the table.
  - The block raises npc_change with the corrected PC on a mispredict, which the hazard unit turns into flushes.
- Keeps saturating statistics counters for branches and mispredicts.

Parameters:
- ENTRIES, 16, number of BTB entries; power of 2, minimum 2.
- IDX_W, $clog2(ENTRIES), index width; index is pc[IDX_W+1:2].
- STAT_W, 16, width of the statistics counters.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- if_pc  input  32  current fetch PC.
- pred_taken  output  1  prediction for if_pc: taken.
- pred_target  output  32  predicted next PC for fetch.
- ex_branch  input  1  resolved branch/jump-register valid in the EX/MEM stage.
- ex_pc  input  32  PC of the resolved branch.
- ex_taken  input  1  actual direction.
- ex_target  input  32  actual taken target.
- ex_pred_taken  input  1  prediction carried down the pipe with this instruction.
- ex_pred_target  input  32  predicted target carried down the pipe.
- ex_stall  input  1  hazard-unit stall of the resolving stage; blocks update/report.
- npc_change  output  1  mispredict; fetch must redirect to npc_correct.
- npc_correct  output  32  architecturally correct next PC.
- branch_count  output  STAT_W  resolved branches, saturating.
- mispred_count  output  STAT_W  mispredicts, saturating.

Behaviour:
- Clock and reset:
  - Single clock CLK.
  - Reset is asynchronous and active-low on nRST.
  - All state is cleared on nRST low regardless of the clock.
- Entry format:
  - Fields: valid, tag = pc[31:IDX_W+2], target[31:2], ctr[1:0].
  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset values:
  - All valid = 0; all ctr = 01; branch_count and mispred_count = 0.
  - Outputs are combinational from state, so after reset pred_taken = 0 and pred_target = if_pc+4.
- Lookup (combinational, 0-cycle latency):
  - Hit when valid and the tag matches if_pc.
  - On a hit with ctr[1] = 1: pred_taken = 1 and pred_target = {target, 2'b00}.
  - Otherwise: pred_taken = 0 and pred_target = if_pc+4.
- Resolve: define commit = ex_branch & ~ex_stall.
- Mispredict:
  - mispred = (ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target).
  - npc_change = commit & mispred, combinational.
  - npc_correct = ex_taken ? ex_target : ex_pc+4; it is driven whenever ex_branch = 1 and is don't-care otherwise.
- Update (on the rising edge when commit = 1), indexed by ex_pc:
  - Hit, taken: ctr saturating increment (11 stays 11); target overwritten with ex_target.
  - Hit, not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Miss, taken: allocate or replace the entry with valid = 1, new tag, target = ex_target, ctr = 10.
  - Miss, not taken: no change (no allocation).
- Statistics:
  - On commit, branch_count += 1.
  - On npc_change, mispred_count += 1.
  - Both saturate at all-ones and never wrap.
- Simultaneous lookup and update of the same index: lookup returns the pre-update entry; the new value is visible the following cycle. There is no bypass.
- ex_stall = 1 with ex_branch = 1:
  - No table or statistics update.
  - npc_change = 0, so each branch is reported exactly once, in the cycle it leaves the stall.
- ex_target is taken with bits [1:0] ignored and stored word-aligned.
- nRST asserted mid-update: the table and counters clear immediately; the pending update is lost.

Test Plan:
- Reset then if_pc = 0x0000_0040 -> pred_taken = 0, pred_target = 0x0000_0044, npc_change = 0, both counters 0.
- Cold taken branch: ex_branch = 1, ex_pc = 0x40, ex_taken = 1, ex_target = 0x100, ex_pred_taken = 0:
  - Same cycle: npc_change = 1, npc_correct = 0x100.
  - Next cycle: if_pc = 0x40 gives pred_taken = 1, pred_target = 0x100.
  - branch_count = 1, mispred_count = 1.
- Counter walk on pc 0x40, outcomes T, T, N, N, N:
  - ctr sequence 10 -> 11 -> 11 -> 10 -> 01 -> 00.
  - pred_taken after the final update = 0.
  - Correctly predicted commits give npc_change = 0.
- Aliasing: train pc 0x40 taken, then resolve pc 0x80 (same index at ENTRIES = 16) taken to 0x200:
  - if_pc = 0x40 -> miss, pred_target = 0x44.
  - if_pc = 0x80 -> 0x200, ctr = 10.
- Stall hold: ex_branch = 1 mispredicted with ex_stall = 1 for 3 cycles, then 0:
  - npc_change = 0 for 3 cycles, then 1 for exactly 1 cycle.
  - branch_count increments by 1 only.
- Saturation and reset: force 2^STAT_W+5 commits -> branch_count = 0xFFFF. Pulse nRST low asynchronously between edges -> counters 0 and all lookups miss before the next CLK edge.

Source files
------------

// File: rtl/branch_predictor.sv
// Dynamic 2-bit branch predictor with a direct-mapped branch target buffer.
// Fetch lookup is combinational; resolved branches train the table and report mispredicts.
module branch_predictor #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int STAT_W  = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [31:0]       if_pc,
   output logic              pred_taken,
   output logic [31:0]       pred_target,
   input  logic              ex_branch,
   input  logic [31:0]       ex_pc,
   input  logic              ex_taken,
   input  logic [31:0]       ex_target,
   input  logic              ex_pred_taken,
   input  logic [31:0]       ex_pred_target,
   input  logic              ex_stall,
   output logic              npc_change,
   output logic [31:0]       npc_correct,
   output logic [STAT_W-1:0] branch_count,
   output logic [STAT_W-1:0] mispred_count
);

   localparam int TAG_W = 32 - IDX_W - 2;

   logic             valid  [ENTRIES];
   logic [TAG_W-1:0] tag    [ENTRIES];
   logic [29:0]      target [ENTRIES];
   logic [1:0]       ctr    [ENTRIES];

   logic [IDX_W-1:0] if_idx;
   logic [IDX_W-1:0] ex_idx;
   logic             if_hit;
   logic             ex_hit;
   logic             commit;
   logic             mispred;

   assign if_idx = if_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign if_hit = valid[if_idx] && (tag[if_idx] == if_pc[31:IDX_W+2]);
   assign ex_hit = valid[ex_idx] && (tag[ex_idx] == ex_pc[31:IDX_W+2]);

   assign pred_taken  = if_hit && ctr[if_idx][1];
   assign pred_target = pred_taken ? {target[if_idx], 2'b00} : if_pc + 32'd4;

   // A stalled branch is neither trained nor reported until it leaves the stall.
   assign commit      = ex_branch && !ex_stall;
   assign mispred     = (ex_taken != ex_pred_taken) ||
                        (ex_taken && ex_pred_taken && (ex_target != ex_pred_target));
   assign npc_change  = commit && mispred;
   assign npc_correct = ex_taken ? ex_target : ex_pc + 32'd4;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid[i]  <= 1'b0;
            tag[i]    <= '0;
            target[i] <= '0;
            ctr[i]    <= 2'b01;
         end
      end else if (commit) begin
         if (ex_hit) begin
            if (ex_taken) begin
               if (ctr[ex_idx] != 2'b11) ctr[ex_idx] <= ctr[ex_idx] + 2'd1;
               target[ex_idx] <= ex_target[31:2];
            end else if (ctr[ex_idx] != 2'b00) begin
               ctr[ex_idx] <= ctr[ex_idx] - 2'd1;
            end
         end else if (ex_taken) begin
            // Not-taken misses never allocate, so only taken branches occupy entries.
            valid[ex_idx]  <= 1'b1;
            tag[ex_idx]    <= ex_pc[31:IDX_W+2];
            target[ex_idx] <= ex_target[31:2];
            ctr[ex_idx]    <= 2'b10;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         branch_count  <= '0;
         mispred_count <= '0;
      end else begin
         if (commit && (branch_count != '1)) branch_count <= branch_count + 1'b1;
         if (npc_change && (mispred_count != '1)) mispred_count <= mispred_count + 1'b1;
      end
   end

endmodule
